// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Module      : shift_sequencer_if
// Description : Command, result and shift-register datapath signals for
//               shift_sequencer, with controller (slave) and environment
//               (master) views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    // Command port
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_amount;
    logic             cmd_rotate;

    // Shift-register datapath
    logic             sr_load;
    logic [WIDTH-1:0] sr_d_in;
    logic             sr_shift_en;
    logic             sr_dir;
    logic             sr_ser_in;
    logic [WIDTH-1:0] sr_q;

    // Result port
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_data,
        input  cmd_dir,
        input  cmd_amount,
        input  cmd_rotate,
        output sr_load,
        output sr_d_in,
        output sr_shift_en,
        output sr_dir,
        output sr_ser_in,
        input  sr_q,
        output res_valid,
        input  res_ready,
        output res_data
    );

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_data,
        output cmd_dir,
        output cmd_amount,
        output cmd_rotate,
        input  sr_load,
        input  sr_d_in,
        input  sr_shift_en,
        input  sr_dir,
        input  sr_ser_in,
        output sr_q,
        input  res_valid,
        output res_ready,
        input  res_data
    );
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Sequences a parallel-load bidirectional shift register through
//               load, N single-bit shifts and result capture per command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] data_q,     data_d;
    logic             dir_q,      dir_d;
    logic [CNT_W-1:0] amount_q,   amount_d;
    logic             rotate_q,   rotate_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    logic             w_ser_in;

    // Model of one datapath shift, used to capture the post-shift word on the
    // same edge the register itself updates.
    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] q,
        input logic             dir,
        input logic             ser
    );
        logic [WIDTH-1:0] r;
        if (dir) begin
            r = {q[WIDTH-2:0], ser};
        end else begin
            r = {ser, q[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign w_ser_in = (state_q == S_SHIFT) && rotate_q &&
                      (dir_q ? bus.sr_q[WIDTH-1] : bus.sr_q[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            dir_q      <= 1'b0;
            amount_q   <= '0;
            rotate_q   <= 1'b0;
            cnt_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            dir_q      <= dir_d;
            amount_q   <= amount_d;
            rotate_q   <= rotate_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        dir_d           = dir_q;
        amount_d        = amount_q;
        rotate_d        = rotate_q;
        cnt_d           = cnt_q;
        res_data_d      = res_data_q;

        bus.cmd_ready   = 1'b0;
        bus.sr_load     = 1'b0;
        bus.sr_d_in     = '0;
        bus.sr_shift_en = 1'b0;
        bus.sr_dir      = 1'b0;
        bus.sr_ser_in   = w_ser_in;
        bus.res_valid   = 1'b0;
        bus.res_data    = res_data_q;
        busy            = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    data_d   = bus.cmd_data;
                    dir_d    = bus.cmd_dir;
                    amount_d = bus.cmd_amount;
                    rotate_d = bus.cmd_rotate;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.sr_load = 1'b1;
                bus.sr_d_in = data_q;
                cnt_d       = amount_q;
                if (amount_q == '0) begin
                    res_data_d = data_q;
                    state_d    = S_DONE;
                end else begin
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bus.sr_shift_en = 1'b1;
                bus.sr_dir      = dir_q;
                cnt_d           = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_data_d = shift_once(bus.sr_q, dir_q, w_ser_in);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer with a behavioural
//               shift-register datapath and an arithmetic result model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    // Datapath register obeying the load/shift contract
    logic [W-1:0] sr_model = '0;
    assign bus.sr_q = sr_model;
    always @(posedge clk) begin
        if (bus.sr_load)
            sr_model <= bus.sr_d_in;
        else if (bus.sr_shift_en)
            sr_model <= bus.sr_dir ? {sr_model[W-2:0], bus.sr_ser_in}
                                   : {bus.sr_ser_in, sr_model[W-1:1]};
    end

    int edge_cnt = 0;
    int n_shift  = 0;
    int n_load   = 0;
    int n_hs     = 0;
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (bus.sr_shift_en) n_shift <= n_shift + 1;
        if (bus.sr_load) n_load <= n_load + 1;
        if (bus.cmd_valid && bus.cmd_ready) n_hs <= n_hs + 1;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected result from shift/rotate arithmetic on the whole word
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input bit dir,
                                               input int amt, input bit rot);
        logic [2*W-1:0] dd;
        int k;
        if (rot) begin
            k  = amt % W;
            dd = {d, d};
            if (dir) begin
                dd = dd << k;
                return dd[2*W-1:W];
            end else begin
                dd = dd >> k;
                return dd[W-1:0];
            end
        end
        if (amt >= W) return '0;
        return dir ? (d << amt) : (d >> amt);
    endfunction

    task automatic run_cmd(input logic [W-1:0] d, input bit dir, input int amt, input bit rot,
                           output logic [W-1:0] rdata, output int lat,
                           output int nsh, output int nld);
        int e0, s0, l0, n;
        rdata = 'x; lat = -1; nsh = -1; nld = -1;
        @(negedge clk);
        bus.cmd_data   = d;
        bus.cmd_dir    = dir;
        bus.cmd_amount = CW'(amt);
        bus.cmd_rotate = rot;
        bus.cmd_valid  = 1'b1;
        bus.res_ready  = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e0 = edge_cnt; s0 = n_shift; l0 = n_load;
        @(negedge clk);
        // Scramble command inputs mid-operation; they must be ignored
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = W'($urandom);
        bus.cmd_dir    = 1'($urandom);
        bus.cmd_amount = CW'($urandom);
        bus.cmd_rotate = 1'($urandom);
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL res_valid_timeout: res_valid=%b required 1", bus.res_valid);
            return;
        end
        lat   = edge_cnt - e0 + 1;
        rdata = bus.res_data;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        nsh = n_shift - s0;
        nld = n_load - l0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.cmd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ready_busy: got %b required 10", {bus.cmd_ready, busy});
        end
        n_cmp++;
        if ({bus.sr_load, bus.sr_shift_en, bus.sr_dir, bus.sr_ser_in, bus.sr_d_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_sr: load=%b shift=%b dir=%b ser=%b d_in=%h required all 0",
                     bus.sr_load, bus.sr_shift_en, bus.sr_dir, bus.sr_ser_in, bus.sr_d_in);
        end
        n_cmp++;
        if ({bus.res_valid, bus.res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_res: valid=%b data=%h required 0/0", bus.res_valid, bus.res_data);
        end
    endtask

    typedef struct {
        logic [W-1:0] d;
        bit           dir;
        int           amt;
        bit           rot;
        logic [W-1:0] exp;
    } vec_t;

    task automatic test_directed;
        vec_t tbl[6];
        logic [W-1:0] r;
        int lat, nsh, nld;
        tbl = '{'{4'b1010, 1'b0, 1, 1'b0, 4'b0101},
                '{4'b1010, 1'b1, 1, 1'b1, 4'b0101},
                '{4'b1001, 1'b1, 4, 1'b1, 4'b1001},
                '{4'b1010, 1'b0, 0, 1'b0, 4'b1010},
                '{4'b1011, 1'b0, 5, 1'b0, 4'b0000},
                '{4'b0001, 1'b1, 3, 1'b0, 4'b1000}};
        foreach (tbl[i]) begin
            run_cmd(tbl[i].d, tbl[i].dir, tbl[i].amt, tbl[i].rot, r, lat, nsh, nld);
            n_cmp++;
            if (r !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL directed_data[%0d]: got %b required %b", i, r, tbl[i].exp);
            end
            n_cmp++;
            if (lat !== 2 + tbl[i].amt) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, 2 + tbl[i].amt);
            end
            n_cmp++;
            if (nsh !== tbl[i].amt) begin
                n_fail++;
                $display("FAIL directed_shifts[%0d]: got %0d required %0d", i, nsh, tbl[i].amt);
            end
            n_cmp++;
            if (nld !== 1) begin
                n_fail++;
                $display("FAIL directed_loads[%0d]: got %0d required 1", i, nld);
            end
            n_cmp++;
            if ({bus.res_valid, busy, bus.cmd_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL directed_idle[%0d]: valid/busy/ready=%b required 001", i,
                         {bus.res_valid, busy, bus.cmd_ready});
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] d, r, e;
        bit dir, rot;
        int amt, lat, nsh, nld;
        for (int i = 0; i < 40; i++) begin
            d   = W'($urandom);
            dir = 1'($urandom);
            rot = 1'($urandom);
            amt = int'($urandom_range(0, (1 << CW) - 1));
            e   = ref_shift(d, dir, amt, rot);
            run_cmd(d, dir, amt, rot, r, lat, nsh, nld);
            n_cmp++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL random_data[%0d] d=%b dir=%0d amt=%0d rot=%0d: got %b required %b",
                         i, d, dir, amt, rot, r, e);
            end
            n_cmp++;
            if (nsh !== amt || lat !== 2 + amt) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: shifts=%0d latency=%0d required %0d/%0d",
                         i, nsh, lat, amt, 2 + amt);
            end
        end
    endtask

    task automatic test_back_to_back;
        int h0, n;
        @(negedge clk);
        bus.cmd_data = 4'b1100; bus.cmd_dir = 1'b0; bus.cmd_amount = CW'(2);
        bus.cmd_rotate = 1'b1; bus.cmd_valid = 1'b1; bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        h0 = n_hs;
        @(negedge clk);
        // Second command presented and held while the first is outstanding
        bus.cmd_data = 4'b0110; bus.cmd_dir = 1'b1; bus.cmd_amount = CW'(1);
        bus.cmd_rotate = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if ({bus.res_valid, bus.res_data, bus.cmd_ready} !== {1'b1, 4'b0011, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%b ready=%b required 1/0011/0",
                         c, bus.res_valid, bus.res_data, bus.cmd_ready);
            end
            n_cmp++;
            if (n_hs !== h0) begin
                n_fail++;
                $display("FAIL backpressure_no_accept[%0d]: handshakes=%0d required %0d", c, n_hs, h0);
            end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_cmp++;
        if ({bus.res_valid, bus.cmd_ready, n_hs == h0} !== 3'b011) begin
            n_fail++;
            $display("FAIL release_idle: valid=%b ready=%b handshakes=%0d required 0/1/%0d",
                     bus.res_valid, bus.cmd_ready, n_hs, h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (n_hs !== h0 + 1) begin
            n_fail++;
            $display("FAIL second_accept: handshakes=%0d required %0d", n_hs, h0 + 1);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1100) begin
            n_fail++;
            $display("FAIL second_result: valid=%b data=%b required 1/1100", bus.res_valid, bus.res_data);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] r;
        int lat, nsh, nld;
        bit seen;
        @(negedge clk);
        bus.cmd_data = 4'b0110; bus.cmd_dir = 1'($urandom); bus.cmd_amount = CW'(7);
        bus.cmd_rotate = 1'b1; bus.cmd_valid = 1'b1; bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.sr_shift_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_shifting: sr_shift_en=%b required 1", bus.sr_shift_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, bus.sr_shift_en, bus.sr_load, bus.cmd_ready, bus.res_valid} !== 5'b00010) begin
            n_fail++;
            $display("FAIL midop_reset: busy/shift/load/ready/valid=%b required 00010",
                     {busy, bus.sr_shift_en, bus.sr_load, bus.cmd_ready, bus.res_valid});
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen |= bus.res_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_result: res_valid seen=%b required 0", seen);
        end
        run_cmd(4'b1101, 1'b0, 3, 1'b1, r, lat, nsh, nld);
        n_cmp++;
        if (r !== ref_shift(4'b1101, 1'b0, 3, 1'b1) || lat !== 5) begin
            n_fail++;
            $display("FAIL after_reset_cmd: data=%b latency=%0d required %b/5",
                     r, lat, ref_shift(4'b1101, 1'b0, 3, 1'b1));
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = '0;
        bus.cmd_dir    = 1'b0;
        bus.cmd_amount = '0;
        bus.cmd_rotate = 1'b0;
        bus.res_ready  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
